// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register bank and its dump walker.
// The dump FSM states and the {index, data} word layout live here.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] index;
        logic [REG_DATA_W-1:0] data;
    } dump_word_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks the register bank read port and streams each register as an
// {index, data} word, holding freezeReq while a dump is in progress.
module regfile_dumper
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rdData,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outIndex,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    output logic              busy,
    output logic              freezeReq,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((SKIP_ZERO != 0) ? 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;
    logic              done_q,  done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = FIRST_IDX;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = rdData;
                index_d = count_q;
                last_d  = (count_q == LAST_IDX);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && outReady) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks a same-cycle handshake, so that word is dropped.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            count_d = '0;
            done_d  = 1'b0;
        end
    end

    assign rdAddr    = count_q;
    assign outValid  = valid_q;
    assign outIndex  = index_q;
    assign outData   = data_q;
    assign outLast   = last_q;
    assign busy      = (state_q != IDLE);
    assign freezeReq = busy;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: two instances (SKIP_ZERO 0 and 1)
// share a bank model preloaded with R[i] = i*3.
module tb_regfile_dumper;
    import regfile_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic abort = 1'b0;
    logic outReady = 1'b1;
    logic sel = 1'b0;
    int   readyMode = 0;

    logic [DW-1:0] bank [N];

    logic          start0, start1, abort0, abort1;
    logic [AW-1:0] rdAddr0, rdAddr1, outIndex0, outIndex1;
    logic [DW-1:0] rdData0, rdData1, outData0, outData1;
    logic          outValid0, outValid1, outLast0, outLast1;
    logic          busy0, busy1, freeze0, freeze1, done0, done1;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign abort0  = abort & ~sel;
    assign abort1  = abort & sel;
    assign rdData0 = bank[rdAddr0];
    assign rdData1 = bank[rdAddr1];

    regfile_dumper #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .rdAddr(rdAddr0), .rdData(rdData0), .outValid(outValid0), .outReady(outReady),
        .outIndex(outIndex0), .outData(outData0), .outLast(outLast0),
        .busy(busy0), .freezeReq(freeze0), .done(done0)
    );

    regfile_dumper #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rdAddr(rdAddr1), .rdData(rdData1), .outValid(outValid1), .outReady(outReady),
        .outIndex(outIndex1), .outData(outData1), .outLast(outLast1),
        .busy(busy1), .freezeReq(freeze1), .done(done1)
    );

    logic          monValid, monLast, monBusy, monFreeze, monDone;
    logic [AW-1:0] monIndex, monRdAddr;
    logic [DW-1:0] monData;

    assign monValid  = sel ? outValid1 : outValid0;
    assign monLast   = sel ? outLast1  : outLast0;
    assign monBusy   = sel ? busy1     : busy0;
    assign monFreeze = sel ? freeze1   : freeze0;
    assign monDone   = sel ? done1     : done0;
    assign monIndex  = sel ? outIndex1 : outIndex0;
    assign monRdAddr = sel ? rdAddr1   : rdAddr0;
    assign monData   = sel ? outData1  : outData0;

    int numChecks = 0;
    int numFails  = 0;
    dump_word_t expQ [$];
    int sampleNo = 0;
    int lastHsSample = -100;
    int doneSeen = 0;
    int expDone = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Bursty consumer: 0 = always ready, 1 = fixed on/off pattern, 2 = stalled
    logic [7:0] readyPat = 8'b1001_1001;
    int         patIdx = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            1: begin
                outReady = readyPat[patIdx % 8];
                patIdx++;
            end
            2:       outReady = 1'b0;
            default: outReady = 1'b1;
        endcase
    end

    // Monitor: every presented word must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            sampleNo++;
            if (monValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious word", monValid, 0);
                end else begin
                    checkOutput("outIndex", monIndex, expQ[0].index);
                    checkOutput("outData", monData, expQ[0].data);
                    checkOutput("outLast", monLast, (expQ[0].index == AW'(N - 1)));
                    checkOutput("rdAddr while sending", monRdAddr, expQ[0].index);
                    checkOutput("busy while sending", monBusy, 1);
                    checkOutput("freezeReq while sending", monFreeze, 1);
                    if (outReady && !abort) begin
                        if (expQ[0].index == AW'(N - 1)) lastHsSample = sampleNo;
                        void'(expQ.pop_front());
                    end
                end
            end
            if (abort && monBusy) expQ.delete();
            if (monDone) begin
                doneSeen++;
                checkOutput("done latency", sampleNo - lastHsSample, 2);
                checkOutput("busy at done", monBusy, 0);
            end
        end
    end

    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic startDump(input int firstIdx);
        for (int i = firstIdx; i < N; i++) begin
            dump_word_t w;
            w.index = AW'(i);
            w.data  = DW'(i * 3);
            expQ.push_back(w);
        end
        applyStimulus();
        checkOutput("busy after start", monBusy, 1);
        checkOutput("outValid in load", monValid, 0);
        @(posedge clk);
        #1;
        checkOutput("first outValid latency", monValid, 1);
    endtask

    task automatic waitDone();
        int cyc = 0;
        while ((expQ.size() != 0 || doneSeen != expDone) && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        checkOutput("words outstanding", expQ.size(), 0);
        checkOutput("done count", doneSeen, expDone);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("single done pulse", doneSeen, expDone);
        checkOutput("idle after dump", monBusy, 0);
    endtask

    task automatic waitForIndex(input int idx, output bit found);
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk);
            #1;
            if (monValid && monIndex == AW'(idx)) found = 1;
        end
        checkOutput("reached target index", found, 1);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < N; i++) bank[i] = DW'(i * 3);

        #3;
        checkOutput("reset outValid", outValid0, 0);
        checkOutput("reset outIndex", outIndex0, 0);
        checkOutput("reset outData", outData0, 0);
        checkOutput("reset outLast", outLast0, 0);
        checkOutput("reset busy", busy0, 0);
        checkOutput("reset freezeReq", freeze0, 0);
        checkOutput("reset done", done0, 0);
        checkOutput("reset rdAddr", rdAddr0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] full dump, consumer always ready");
        startDump(0);
        expDone++;
        waitDone();

        $display("[TB] full dump skipping x0");
        sel = 1'b1;
        startDump(1);
        expDone++;
        waitDone();
        sel = 1'b0;

        $display("[TB] full dump with bursty consumer");
        readyMode = 1;
        startDump(0);
        expDone++;
        waitDone();
        readyMode = 0;
        @(posedge clk);
        #1;

        $display("[TB] abort on handshake of index 10");
        startDump(0);
        waitForIndex(10, found);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("outValid after abort", monValid, 0);
        checkOutput("busy after abort", monBusy, 0);
        checkOutput("rdAddr after abort", monRdAddr, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no done after abort", doneSeen, expDone);
        startDump(0);
        expDone++;
        waitDone();

        $display("[TB] start while busy is ignored");
        startDump(0);
        expDone++;
        waitForIndex(5, found);
        applyStimulus();
        waitDone();

        $display("[TB] async reset mid-send");
        readyMode = 2;
        @(posedge clk);
        #1;
        startDump(0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("async reset outValid", outValid0, 0);
        checkOutput("async reset outIndex", outIndex0, 0);
        checkOutput("async reset busy", busy0, 0);
        checkOutput("async reset freezeReq", freeze0, 0);
        checkOutput("async reset rdAddr", rdAddr0, 0);
        #1;
        reset = 1'b0;
        readyMode = 0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("outValid stays low after reset", outValid0, 0);
        checkOutput("no done after reset", doneSeen, expDone);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
